// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART constants (parity modes), receiver FSM encoding and
//            a parity-check helper used by the receiver and the transmitter.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

  // True when the received parity bit disagrees with the configured mode.
  // data_xor is the XOR reduction of the payload.
  function automatic logic parity_bad(input logic data_xor, input logic pbit,
                                      input int unsigned mode);
    return (data_xor ^ pbit) != (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Purpose  : Bit-phase counter. Counts 0..CLKS_PER_BIT-1 and wraps; flags the
//            half-period point (start-bit centre) and the full-period point
//            (every later bit centre). restart forces the count to zero.
// Revision : 1.0  initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic half_tick,
  output logic full_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign half_tick = (cnt_q == CNT_W'(CLKS_PER_BIT/2 - 1));
  assign full_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Next count: restart wins, otherwise count up and reload at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (full_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised UART receiver. Synchronises rxd, rejects start-bit
//            glitches, shifts in DATA_BITS LSB-first, checks optional parity
//            and STOP_BITS stop bits, and presents the frame in a held output
//            register with valid/ready handshake and sticky overrun.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rx_en,
  input  logic                 rx_ready,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  // Synchroniser chain plus one extra stage for falling-edge detection.
  logic sync1_q;
  logic sync2_q;
  logic rxd_prev_q;
  logic rxd_sync;

  // Frame FSM and datapath.
  rx_state_e            state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frm_bad_q, frm_bad_d;
  logic                 frame_done;

  // Held output register.
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  // Phase counter interface.
  logic cnt_restart;
  logic half_tick;
  logic full_tick;

  assign rxd_sync = sync2_q;

  // Counter is parked at zero in IDLE and realigned once the start bit centre
  // is confirmed, so every later full tick lands on a bit centre.
  assign cnt_restart = (state_q == RX_IDLE) || ((state_q == RX_START) && half_tick);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk       (clk),
    .rst       (rst),
    .restart   (cnt_restart),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      rxd_prev_q <= sync2_q;
    end
  end

  // Frame FSM: next state, bit counting, shifting and error accumulation.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    frm_bad_d  = frm_bad_q;
    frame_done = 1'b0;

    case (state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (rx_en && rxd_prev_q && !rxd_sync) begin
          state_d = RX_START;
        end
      end

      RX_START: begin
        if (half_tick) begin
          if (rxd_sync) begin
            // Line went back high before mid-bit: treat as noise.
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
            frm_bad_d = 1'b0;
          end
        end
      end

      RX_DATA: begin
        if (full_tick) begin
          shift_d = {rxd_sync, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      RX_PARITY: begin
        if (full_tick) begin
          par_bad_d = parity_bad(^shift_q, rxd_sync, PARITY);
          state_d   = RX_STOP;
        end
      end

      RX_STOP: begin
        if (full_tick) begin
          if (!rxd_sync) begin
            frm_bad_d = 1'b1;
          end
          if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            bit_cnt_d  = '0;
            // A low last stop bit means a break: wait for the line to recover
            // so the remaining low time is not mistaken for a start edge.
            state_d    = rxd_sync ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      RX_WAIT_HIGH: begin
        if (rxd_sync) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase

    // Disabling the receiver abandons any partial frame.
    if (!rx_en) begin
      state_d    = RX_IDLE;
      bit_cnt_d  = '0;
      frame_done = 1'b0;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      frm_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      frm_bad_q <= frm_bad_d;
    end
  end

  // Held output register: load on completion if free or being drained,
  // otherwise drop the new frame and flag overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (err_clr) begin
      ovr_d = 1'b0;
    end

    if (frame_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        perr_d  = par_bad_q;
        ferr_d  = frm_bad_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != RX_IDLE);

endmodule
`default_nettype wire
